// File: rtl/iterative_alu.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Shifts advance one bit per cycle; every other operation finishes in a single cycle.
module iterative_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] work;
  logic [SW-1:0]    count;

  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic             lt;
  logic [WIDTH-1:0] alu_value;
  logic [WIDTH-1:0] step_value;

  assign shamt    = b[SW-1:0];
  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign lt       = $signed(a) < $signed(b);

  always_comb begin
    alu_value = '0;
    case (Operation)
      OP_AND: alu_value = a & b;
      OP_OR:  alu_value = a | b;
      OP_ADD: alu_value = a + b;
      OP_SUB: alu_value = a - b;
      OP_XOR: alu_value = a ^ b;
      OP_SLT: alu_value = {{(WIDTH-1){1'b0}}, lt};
      // Only reached for a zero shift amount; nonzero shifts go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: alu_value = a;
      default: alu_value = '0;
    endcase
  end

  always_comb begin
    step_value = work;
    case (op_reg)
      OP_SLL:  step_value = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  step_value = {1'b0, work[WIDTH-1:1]};
      OP_SRA:  step_value = {work[WIDTH-1], work[WIDTH-1:1]};
      default: step_value = work;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op_reg    <= '0;
      work      <= '0;
      count     <= '0;
      result    <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            op_reg   <= Operation;
            if (is_shift && (shamt != '0)) begin
              state <= SHIFT;
              work  <= a;
              count <= shamt;
            end else begin
              state     <= DONE;
              result    <= alu_value;
              zero      <= (alu_value == '0);
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work  <= step_value;
          count <= count - 1'b1;
          // The step taken while count is 1 is the last one.
          if (count == SW'(1)) begin
            state     <= DONE;
            result    <= step_value;
            zero      <= (step_value == '0);
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: inputs are driven and outputs sampled on the falling edge.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;

  int tests  = 0;
  int failed = 0;

  iterative_alu #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (operation),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request with out_ready high, measure cycles until out_valid, then check the result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] exp_res,
                        input logic exp_zero, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    operation = op;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, {63'd0, zero}, {63'd0, exp_zero});
    @(negedge clk);
    check({tag, " in_ready after consume"}, {63'd0, in_ready}, 64'd1);
    $display("[TB] %s op=%b a=%h b=%h -> result=%h zero=%0d latency=%0d",
             tag, op, av, bv, exp_res, exp_zero, exp_lat);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    operation = 4'b0000;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    #12;
    check("reset result", result, 64'd0);
    check("reset zero", {63'd0, zero}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    $display("[TB] reset state checked");
    @(negedge clk);
    reset_n = 1'b1;

    // ADD 7+5 with explicit cycle-by-cycle handshake checks
    @(negedge clk);
    in_valid = 1'b1; operation = 4'b0010; a = 64'h7; b = 64'h5; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("add7+5 out_valid", {63'd0, out_valid}, 64'd1);
    check("add7+5 result", result, 64'hC);
    check("add7+5 zero", {63'd0, zero}, 64'd0);
    check("add7+5 in_ready busy", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("add7+5 in_ready back", {63'd0, in_ready}, 64'd1);
    check("add7+5 out_valid drop", {63'd0, out_valid}, 64'd0);
    $display("[TB] add 7+5 handshake checked");

    run_op("sub_equal", 4'b0110, 64'h1234, 64'h1234, 64'd0, 1'b1, 1);
    run_op("add_wrap",  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1);
    run_op("sub_neg",   4'b0110, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);
    run_op("and",       4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1);
    run_op("or",        4'b0001, 64'hF0F0, 64'h0F0F, 64'hFFFF, 1'b0, 1);
    run_op("xor",       4'b0111, 64'hFF00, 64'h0FF0, 64'hF0F0, 1'b0, 1);
    run_op("slt_true",  4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 1);
    run_op("slt_false", 4'b1000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1);
    run_op("bad_op",    4'b1111, 64'h1234, 64'h5678, 64'd0, 1'b1, 1);
    run_op("sra4",      4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1'b0, 5);
    run_op("srl4",      4'b0100, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 5);
    run_op("sll1",      4'b0011, 64'h8000_0000_0000_0001, 64'd1, 64'h2, 1'b0, 2);
    run_op("sll63",     4'b0011, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 64);
    run_op("sll0",      4'b0011, 64'hABCD, 64'd0, 64'hABCD, 1'b0, 1);
    run_op("sra_mask",  4'b0101, 64'h4000_0000_0000_0000, 64'h42, 64'h1000_0000_0000_0000, 1'b0, 3);

    // Stall in DONE while the request side keeps changing
    @(negedge clk);
    in_valid = 1'b1; operation = 4'b0010; a = 64'h10; b = 64'h20; out_ready = 1'b0;
    @(negedge clk);
    check("stall out_valid", {63'd0, out_valid}, 64'd1);
    check("stall result", result, 64'h30);
    for (int i = 0; i < 3; i++) begin
      operation = 4'b0110;
      a = 64'(i + 100);
      b = 64'd7;
      @(negedge clk);
      check("stall hold result", result, 64'h30);
      check("stall hold zero", {63'd0, zero}, 64'd0);
      check("stall in_ready", {63'd0, in_ready}, 64'd0);
      check("stall hold out_valid", {63'd0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall consumed out_valid", {63'd0, out_valid}, 64'd0);
    check("stall consumed in_ready", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    $display("[TB] stall of 3 cycles then consume checked");

    // Reset in the middle of a long shift
    @(negedge clk);
    in_valid = 1'b1; operation = 4'b0011; a = 64'd1; b = 64'd40; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-shift out_valid", {63'd0, out_valid}, 64'd0);
    check("mid-shift in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", {63'd0, out_valid}, 64'd0);
    check("async reset result", result, 64'd0);
    check("async reset zero", {63'd0, zero}, 64'd1);
    check("async reset in_ready", {63'd0, in_ready}, 64'd1);
    $display("[TB] reset during sll b=40 checked");
    @(negedge clk);
    reset_n = 1'b1;
    run_op("add_after_reset", 4'b0010, 64'd2, 64'd3, 64'd5, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  request present on Operation/a/b.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port Operation  input  4  ALU operation code from the ALU control decoder.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B (shift amount in b[5:0] for shifts).
REQ-009 SHALL have port out_valid  output  1  result/zero valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  registered flag, 1 when result == 0.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept a request on a rising edge in IDLE with in_valid = 1, capturing Operation, a, b.
REQ-016 SHALL decode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 signed less-than (result 1 if a < b signed else 0), 0011 SLL, 0100 SRL, 0101 SRA, 0111 XOR.
REQ-017 SHALL produce result 0 for any other opcode, with single-cycle latency.
REQ-018 SHALL truncate ADD/SUB to WIDTH bits (modulo 2^WIDTH), no overflow flag.
REQ-019 SHALL, for non-shift ops, go IDLE -> DONE at the accept edge, so out_valid rises on the cycle after the accept.
REQ-020 SHALL, for shifts with shamt = b[5:0] (masked to log2(WIDTH) bits), go IDLE -> SHIFT, shift the working register one bit per cycle, and load a counter with shamt.
REQ-021 SHALL decrement the counter each SHIFT cycle and go SHIFT -> DONE on the edge where the counter reaches 0; total latency = 1 + shamt cycles.
REQ-022 SHALL treat shamt = 0 as a non-shift op: IDLE -> DONE with result = a.
REQ-023 SHALL have SRA replicate bit WIDTH-1 on each step; SRL and SLL shall insert 0.
REQ-024 SHALL hold result and zero stable in DONE until out_valid && out_ready, then go to IDLE on that edge.
REQ-025 SHALL NOT accept a new request in the same cycle a result is consumed; next accept is earliest one cycle later.
REQ-026 SHALL ignore in_valid, Operation, a and b while in SHIFT or DONE.
REQ-027 SHALL update zero together with result on every result register write.

Reset
REQ-028 SHALL, on reset_n = 0 at any time including mid-SHIFT, immediately force state IDLE, result = 0, zero = 1, out_valid = 0, in_ready = 1, counter = 0.
REQ-029 SHALL, after reset_n deasserts, accept a request on the first rising edge with in_valid = 1.

Verification
REQ-030 SHALL cover: ADD a=0x7, b=0x5, out_ready=1 -> out_valid on next cycle, result 0xC, zero 0, in_ready 1 one cycle later.
REQ-031 SHALL cover: SUB a=b=0x1234 -> result 0, zero 1; ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result 0, zero 1.
REQ-032 SHALL cover: SRA a=0x8000_0000_0000_0000, b=4 -> out_valid 5 cycles after accept, result 0xF800_0000_0000_0000; SRL same operands -> 0x0800_0000_0000_0000.
REQ-033 SHALL cover: LT a=-1, b=1 -> result 1, zero 0; opcode 1111 -> result 0, zero 1, 1-cycle latency.
REQ-034 SHALL cover: out_ready held 0 for 3 cycles in DONE with in_valid = 1 and changing operands -> result and zero unchanged, in_ready 0; consumed on the cycle out_ready rises.
REQ-035 SHALL cover: reset_n pulsed low during SLL with b=40, after 10 shift cycles -> immediately out_valid 0, result 0, zero 1, in_ready 1; a following ADD 2+3 returns 5.
